// File: rtl/wb_dma_arbiter.sv
// wb_dma_arbiter: two-master Wishbone arbiter (CPU, DMA) in front of one
// slave side. A four-state registered FSM decides ownership. The slave-side
// strobes and the acknowledge returned to each master are combinational.
// The CPU keeps the bus until its open cycle completes, and the DMA is never
// cut off mid-cycle.
// Optional feature: define ARB_TIMEOUT_EN to build the stalled-strobe
// timeout. When a slave does not acknowledge within TMO_CYCLES clocks, the
// arbiter forces an ack to the owner and pulses tmo_o. Without the macro,
// tmo_o is tied low and TMO_CYCLES has no effect.
module wb_dma_arbiter #(
  parameter logic [7:0] TMO_CYCLES = 8'd64
) (
  input  logic clk_p,
  input  logic rst_n,
  input  logic cpu_cyc_i,
  input  logic cpu_stb_i,
  output logic cpu_ack_o,
  output logic cpu_gnt_o,
  input  logic dma_req_i,
  input  logic dma_cyc_i,
  input  logic dma_stb_i,
  output logic dma_ack_o,
  output logic dma_gnt_o,
  output logic wb_cyc_o,
  output logic wb_stb_o,
  input  logic wb_ack_i,
  output logic bus_own_o,
  output logic tmo_o
);

  typedef enum logic [1:0] {
    ST_CPU  = 2'd0,  // CPU owns the bus and may start new cycles
    ST_WAIT = 2'd1,  // DMA pending; CPU finishes its open cycle
    ST_DMA  = 2'd2,  // DMA owns the bus
    ST_REL  = 2'd3   // one dead cycle after DMA, nobody granted
  } state_t;

  state_t state_q, state_d;
  logic   own_cpu, own_dma;
  logic   tmo_hit;
  logic   ack_eff;

  // State register; reset hands the bus straight back to the CPU.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; combinational blocks use blocking (=).
  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) state_q <= ST_CPU;
    else        state_q <= state_d;
  end

  // Next-state decode plus grant, owner and slave-side strobe muxing.
  // NOTE: every output of this block gets a default first so no path
  // through the case statement can infer a latch.
  always_comb begin
    state_d   = state_q;
    cpu_gnt_o = 1'b0;
    dma_gnt_o = 1'b0;
    bus_own_o = 1'b0;
    own_cpu   = 1'b0;
    own_dma   = 1'b0;
    wb_cyc_o  = 1'b0;
    wb_stb_o  = 1'b0;
    case (state_q)
      ST_CPU: begin
        cpu_gnt_o = 1'b1;
        own_cpu   = 1'b1;
        wb_cyc_o  = cpu_cyc_i;
        wb_stb_o  = cpu_stb_i;
        // An open (or just opening) CPU cycle must finish before the DMA gets in.
        if (dma_req_i) state_d = cpu_cyc_i ? ST_WAIT : ST_DMA;
      end
      ST_WAIT: begin
        own_cpu  = 1'b1;
        wb_cyc_o = cpu_cyc_i;
        wb_stb_o = cpu_stb_i;
        // A withdrawn request wins over a simultaneous CPU cycle end, so the
        // bus is not handed to a master that no longer wants it.
        if (!dma_req_i)      state_d = ST_CPU;
        else if (!cpu_cyc_i) state_d = ST_DMA;
      end
      ST_DMA: begin
        dma_gnt_o = 1'b1;
        bus_own_o = 1'b1;
        own_dma   = 1'b1;
        wb_cyc_o  = dma_cyc_i;
        wb_stb_o  = dma_stb_i;
        if (!dma_req_i && !dma_cyc_i) state_d = ST_REL;
      end
      default: begin
        state_d = ST_CPU;
      end
    endcase
  end

`ifdef ARB_TIMEOUT_EN
  logic [7:0] tmo_cnt_q;

  // The limit only matters while a strobe is actually outstanding.
  assign tmo_hit = wb_cyc_o & wb_stb_o & (tmo_cnt_q == TMO_CYCLES);

  // Counts cycles of an unacknowledged strobe. It restarts on ack, on an
  // idle strobe, on a forced ack and on any ownership change.
  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= 8'd0;
    end else if (wb_ack_i || !wb_stb_o || tmo_hit || (state_d != state_q)) begin
      tmo_cnt_q <= 8'd0;
    end else if (wb_cyc_o) begin
      tmo_cnt_q <= tmo_cnt_q + 8'd1;
    end
  end
`else
  logic unused_tmo_cycles;

  assign unused_tmo_cycles = ^TMO_CYCLES;
  assign tmo_hit           = 1'b0;
`endif

  // A forced ack and a real ack in the same cycle collapse into one ack.
  assign ack_eff   = wb_ack_i | tmo_hit;
  assign cpu_ack_o = own_cpu & ack_eff;
  assign dma_ack_o = own_dma & ack_eff;
  assign tmo_o     = tmo_hit;

endmodule

// File: tb/tb_wb_dma_arbiter.sv
// tb_wb_dma_arbiter: directed bench for wb_dma_arbiter (TMO_CYCLES = 4).
// An ownership model (who owns the bus, whether a DMA request is pending, and
// how long the current strobe has stalled) predicts every output. The model
// is compared on each falling clock edge. Literal checks at key points pin
// the model to hand-derived values. Works with or without ARB_TIMEOUT_EN.
module tb_wb_dma_arbiter;

  localparam int TMO = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  localparam int OWN_CPU  = 0;
  localparam int OWN_DMA  = 1;
  localparam int OWN_NONE = 2;

  logic clk_p = 1'b0;
  logic rst_n;
  logic cpu_cyc_i, cpu_stb_i, dma_req_i, dma_cyc_i, dma_stb_i, wb_ack_i;
  logic cpu_ack_o, cpu_gnt_o, dma_ack_o, dma_gnt_o;
  logic wb_cyc_o, wb_stb_o, bus_own_o, tmo_o;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  // Model state: owner, pending DMA request while CPU finishes, stall length.
  int m_own   = OWN_CPU;
  bit m_pend  = 1'b0;
  int m_stall = 0;

  wb_dma_arbiter #(.TMO_CYCLES(8'd4)) dut (
    .clk_p     (clk_p),
    .rst_n     (rst_n),
    .cpu_cyc_i (cpu_cyc_i),
    .cpu_stb_i (cpu_stb_i),
    .cpu_ack_o (cpu_ack_o),
    .cpu_gnt_o (cpu_gnt_o),
    .dma_req_i (dma_req_i),
    .dma_cyc_i (dma_cyc_i),
    .dma_stb_i (dma_stb_i),
    .dma_ack_o (dma_ack_o),
    .dma_gnt_o (dma_gnt_o),
    .wb_cyc_o  (wb_cyc_o),
    .wb_stb_o  (wb_stb_o),
    .wb_ack_i  (wb_ack_i),
    .bus_own_o (bus_own_o),
    .tmo_o     (tmo_o)
  );

  always #5 clk_p = ~clk_p;

  task automatic check(input string name, input logic actual, input logic expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s at %0t: got %0b expected %0b", name, $time, actual, expected);
  endtask

  // Slave-side view the owner should be presenting right now.
  function automatic bit e_cyc();
    if (m_own == OWN_CPU) return cpu_cyc_i;
    if (m_own == OWN_DMA) return dma_cyc_i;
    return 1'b0;
  endfunction

  function automatic bit e_stb();
    if (m_own == OWN_CPU) return cpu_stb_i;
    if (m_own == OWN_DMA) return dma_stb_i;
    return 1'b0;
  endfunction

  function automatic bit e_hit();
    return TMO_ON && (m_stall == TMO) && e_cyc() && e_stb();
  endfunction

  // Ownership model advanced once per clock from the pre-edge inputs.
  always @(posedge clk_p or negedge rst_n) begin : model
    int nown;
    bit npend;
    int nstall;
    if (!rst_n) begin
      m_own   <= OWN_CPU;
      m_pend  <= 1'b0;
      m_stall <= 0;
    end else begin
      nown  = m_own;
      npend = m_pend;
      if (m_own == OWN_NONE) begin
        nown = OWN_CPU;
      end else if (m_own == OWN_DMA) begin
        if (!dma_req_i && !dma_cyc_i) nown = OWN_NONE;
      end else if (!m_pend) begin
        if (dma_req_i) begin
          if (cpu_cyc_i) npend = 1'b1;
          else           nown  = OWN_DMA;
        end
      end else if (!dma_req_i) begin
        npend = 1'b0;
      end else if (!cpu_cyc_i) begin
        npend = 1'b0;
        nown  = OWN_DMA;
      end
      if (nown != m_own || npend != m_pend || wb_ack_i || !e_stb() || e_hit())
        nstall = 0;
      else if (e_cyc())
        nstall = m_stall + 1;
      else
        nstall = m_stall;
      m_own   <= nown;
      m_pend  <= npend;
      m_stall <= nstall;
    end
  end

  // Compare every DUT output against the model away from the active edge.
  always @(negedge clk_p) begin
    if (cmp_en) begin
      check("cpu_gnt", cpu_gnt_o, (m_own == OWN_CPU) && !m_pend);
      check("dma_gnt", dma_gnt_o, m_own == OWN_DMA);
      check("bus_own", bus_own_o, m_own == OWN_DMA);
      check("wb_cyc",  wb_cyc_o,  e_cyc());
      check("wb_stb",  wb_stb_o,  e_stb());
      check("cpu_ack", cpu_ack_o, (m_own == OWN_CPU) && (wb_ack_i || e_hit()));
      check("dma_ack", dma_ack_o, (m_own == OWN_DMA) && (wb_ack_i || e_hit()));
      check("tmo",     tmo_o,     e_hit());
    end
  end

  task automatic tick();
    @(posedge clk_p);
    #1;
  endtask

  initial begin
    cpu_cyc_i = 0; cpu_stb_i = 0; dma_req_i = 0;
    dma_cyc_i = 0; dma_stb_i = 0; wb_ack_i  = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_cpu_gnt", cpu_gnt_o, 1'b1);
    check("rst_dma_gnt", dma_gnt_o, 1'b0);
    check("rst_bus_own", bus_own_o, 1'b0);
    check("rst_tmo",     tmo_o,     1'b0);
    cmp_en = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Idle CPU: DMA is granted on the very next edge.
    dma_req_i = 1;
    tick();
    check("grant_dma_gnt", dma_gnt_o, 1'b1);
    check("grant_bus_own", bus_own_o, 1'b1);
    check("grant_cpu_gnt", cpu_gnt_o, 1'b0);

    // DMA transfer, slave acks on the third strobe cycle.
    dma_cyc_i = 1; dma_stb_i = 1;
    #1 check("dma_wb_cyc", wb_cyc_o, 1'b1);
    tick(); tick();
    wb_ack_i = 1;
    #1;
    check("dma_ack_routed", dma_ack_o, 1'b1);
    check("dma_ack_not_cpu", cpu_ack_o, 1'b0);
    tick();
    wb_ack_i = 0; dma_cyc_i = 0; dma_stb_i = 0; dma_req_i = 0;

    // Release: one dead cycle that gates even an eager CPU, then CPU again.
    tick();
    cpu_cyc_i = 1; cpu_stb_i = 1;
    #1;
    check("rel_cpu_gnt", cpu_gnt_o, 1'b0);
    check("rel_dma_gnt", dma_gnt_o, 1'b0);
    check("rel_wb_cyc",  wb_cyc_o,  1'b0);
    tick();
    check("back_cpu_gnt", cpu_gnt_o, 1'b1);
    check("back_wb_cyc",  wb_cyc_o,  1'b1);

    // DMA request while CPU cycle is open: CPU completes first.
    dma_req_i = 1;
    tick();
    check("wait_cpu_gnt", cpu_gnt_o, 1'b0);
    check("wait_dma_gnt", dma_gnt_o, 1'b0);
    check("wait_wb_cyc",  wb_cyc_o,  1'b1);
    tick(); tick();
    wb_ack_i = 1;
    #1;
    check("wait_cpu_ack", cpu_ack_o, 1'b1);
    check("wait_dma_ack", dma_ack_o, 1'b0);
    tick();
    wb_ack_i = 0; cpu_cyc_i = 0; cpu_stb_i = 0;
    #1 check("wait_hold_dma_gnt", dma_gnt_o, 1'b0);
    tick();
    check("handover_dma_gnt", dma_gnt_o, 1'b1);
    dma_req_i = 0;
    tick(); tick();
    check("return_cpu_gnt", cpu_gnt_o, 1'b1);

    // Rising CPU cycle together with a DMA request goes to WAIT; withdraw.
    cpu_cyc_i = 1; cpu_stb_i = 1; dma_req_i = 1;
    tick();
    check("race_dma_gnt", dma_gnt_o, 1'b0);
    check("race_cpu_gnt", cpu_gnt_o, 1'b0);
    dma_req_i = 0;
    tick();
    check("withdraw_cpu_gnt", cpu_gnt_o, 1'b1);

    // Unacked CPU strobe: forced ack and tmo pulse after 4 stalled cycles.
    repeat (TMO) tick();
    check("tmo_pulse",      tmo_o,     TMO_ON);
    check("tmo_forced_ack", cpu_ack_o, TMO_ON);
    tick();
    check("tmo_clear",     tmo_o,     1'b0);
    check("tmo_ack_clear", cpu_ack_o, 1'b0);
    // Real ack coinciding with the limit: one ack, tmo still flagged.
    repeat (TMO) tick();
    wb_ack_i = 1;
    #1;
    check("tmo_coinc_ack", cpu_ack_o, 1'b1);
    check("tmo_coinc_tmo", tmo_o,     TMO_ON);
    tick();
    wb_ack_i = 0; cpu_cyc_i = 0; cpu_stb_i = 0;

    // Asynchronous reset in the middle of a DMA cycle.
    dma_req_i = 1;
    tick();
    dma_cyc_i = 1; dma_stb_i = 1; cpu_cyc_i = 1;
    #1 check("pre_rst_dma_gnt", dma_gnt_o, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_dma_gnt", dma_gnt_o, 1'b0);
    check("arst_cpu_gnt", cpu_gnt_o, 1'b1);
    check("arst_bus_own", bus_own_o, 1'b0);
    check("arst_wb_cyc",  wb_cyc_o,  1'b1);
    cpu_cyc_i = 0;
    #1 check("arst_wb_cyc_follow", wb_cyc_o, 1'b0);
    tick();
    rst_n = 1'b1; dma_req_i = 0; dma_cyc_i = 0; dma_stb_i = 0;
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
